// File: rtl/ascon_round_ctrl_pkg.sv
// Shared types and constants for the ASCON permutation round controller.
package ascon_round_ctrl_pkg;

  // Index of the final round; every permutation variant ends here
  localparam int LAST_ROUND = 11;

  // Start round index for each permutation length (shorter variants skip early rounds)
  localparam logic [3:0] ROUND_START_P12 = 4'd0;
  localparam logic [3:0] ROUND_START_P8  = 4'd4;
  localparam logic [3:0] ROUND_START_P6  = 4'd6;

  typedef enum logic [1:0] {
    P12  = 2'b00,
    P8   = 2'b01,
    P6   = 2'b10,
    RSVD = 2'b11
  } type_round_mode;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } type_ctrl_state;

  // Round constants for the constant-addition layer, indexed by round index
  localparam logic [7:0] ROUND_CONST [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  // Round constant lookup; out-of-range indices yield zero
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    if (idx <= 4'(LAST_ROUND)) rc = ROUND_CONST[idx];
    return rc;
  endfunction

  // First round index for a given permutation length
  function automatic logic [3:0] round_start(input type_round_mode mode);
    logic [3:0] idx;
    case (mode)
      P8:      idx = ROUND_START_P8;
      P6:      idx = ROUND_START_P6;
      default: idx = ROUND_START_P12;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/ascon_round_ctrl_round_counter.sv
// Loadable round index counter with a terminal flag at the last round.
// Wraps back to zero after the last round so the index never exceeds it.
module ascon_round_ctrl_round_counter #(
  parameter int ROUND_W    = 4,
  parameter int LAST_ROUND = 11
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               load,
  input  logic [ROUND_W-1:0] load_val,
  input  logic               en,
  output logic [ROUND_W-1:0] count,
  output logic               terminal
);

  logic [ROUND_W-1:0] count_reg;
  logic [ROUND_W-1:0] count_next;

  assign terminal = (count_reg == ROUND_W'(LAST_ROUND));
  assign count    = count_reg;

  // Load takes priority; otherwise step forward, wrapping to zero at the last round
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (en) begin
      count_next = terminal ? '0 : count_reg + ROUND_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (srst) count_reg <= '0;
    else      count_reg <= count_next;
  end

endmodule

// File: rtl/ascon_round_ctrl.sv
// ASCON permutation round controller: one round per clock, p12/p8/p6 selected
// by start round index, with a one-cycle completion pulse to the mode FSM.
module ascon_round_ctrl
  import ascon_round_ctrl_pkg::*;
#(
  parameter int ROUND_W    = 4,
  parameter int LAST_ROUND = ascon_round_ctrl_pkg::LAST_ROUND
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  output logic               ready_o,
  output logic [ROUND_W-1:0] round_o,
  output logic               en_state_o,
  output logic               sel_init_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  type_ctrl_state     state_reg;
  type_ctrl_state     state_next;
  type_round_mode     mode_sel;
  logic               accept;
  logic               reject;
  logic               sel_init_reg;
  logic               err_reg;
  logic               round_en;
  logic               round_last;
  logic [ROUND_W-1:0] round_start_idx;

  assign mode_sel        = type_round_mode'(mode_i);
  assign accept          = (state_reg == ST_IDLE) && start_i && (mode_sel != RSVD);
  assign reject          = (state_reg == ST_IDLE) && start_i && (mode_sel == RSVD);
  assign round_en        = (state_reg == ST_RUN);
  assign round_start_idx = ROUND_W'(round_start(mode_sel));

  ascon_round_ctrl_round_counter #(
    .ROUND_W    (ROUND_W),
    .LAST_ROUND (LAST_ROUND)
  ) u_round_counter (
    .clk      (clock_i),
    .srst     (reset_i),
    .load     (accept),
    .load_val (round_start_idx),
    .en       (round_en),
    .count    (round_o),
    .terminal (round_last)
  );

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state: RUN until the last round, then a single DONE cycle back to IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (round_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered pulses: initial-state select on first RUN cycle, error after a reserved-mode start
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sel_init_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      sel_init_reg <= accept;
      err_reg      <= reject;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    ready_o    = 1'b0;
    en_state_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_reg)
      ST_IDLE: ready_o = 1'b1;
      ST_RUN: begin
        en_state_o = 1'b1;
        busy_o     = 1'b1;
      end
      ST_DONE: done_o = 1'b1;
      default: ready_o = 1'b0;
    endcase
    sel_init_o = sel_init_reg;
    err_o      = err_reg;
  end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl: per-cycle expected outputs are
// queued when stimulus is driven and compared one cycle at a time.
module tb_ascon_round_ctrl;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic [1:0] mode_i;
  logic       ready_o;
  logic [3:0] round_o;
  logic       en_state_o;
  logic       sel_init_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  ascon_round_ctrl dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .ready_o    (ready_o),
    .round_o    (round_o),
    .en_state_o (en_state_o),
    .sel_init_o (sel_init_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic [3:0] round;
    logic       en;
    logic       sel;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  typedef struct {
    logic [1:0] mode;
    int         start_idx;
    int         n_rounds;
    bit         is_err;
  } vec_t;

  out_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic out_t idle_rec(input bit err);
    out_t r;
    r = '0;
    r.ready = 1'b1;
    r.err   = err;
    return r;
  endfunction

  function automatic out_t run_rec(input int rnd, input bit sel);
    out_t r;
    r = '0;
    r.round = 4'(rnd);
    r.en    = 1'b1;
    r.busy  = 1'b1;
    r.sel   = sel;
    return r;
  endfunction

  function automatic out_t done_rec();
    out_t r;
    r = '0;
    r.done = 1'b1;
    return r;
  endfunction

  // Expected trace of one permutation from the acceptance edge onward
  task automatic push_perm(input int start_idx, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(run_rec(start_idx + i, i == 0));
    exp_q.push_back(done_rec());
    exp_q.push_back(idle_rec(1'b0));
  endtask

  // Advance one clock and compare outputs against the next expectation
  task automatic tick(input string name);
    out_t act;
    out_t exp;
    @(posedge clk);
    #1;
    act = '{ready_o, round_o, en_state_o, sel_init_o, busy_o, done_o, err_o};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: no expectation queued, got %b", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        miscompares++;
        $display("FAIL %s: got rdy=%b rnd=%0d en=%b sel=%b busy=%b done=%b err=%b, want rdy=%b rnd=%0d en=%b sel=%b busy=%b done=%b err=%b",
                 name, act.ready, act.round, act.en, act.sel, act.busy, act.done, act.err,
                 exp.ready, exp.round, exp.en, exp.sel, exp.busy, exp.done, exp.err);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   n;
    int   bad0;

    vecs[0] = '{mode: 2'b00, start_idx: 0, n_rounds: 12, is_err: 1'b0};
    vecs[1] = '{mode: 2'b01, start_idx: 4, n_rounds: 8,  is_err: 1'b0};
    vecs[2] = '{mode: 2'b10, start_idx: 6, n_rounds: 6,  is_err: 1'b0};
    vecs[3] = '{mode: 2'b11, start_idx: 0, n_rounds: 0,  is_err: 1'b1};

    reset_i = 1'b1;
    start_i = 1'b0;
    mode_i  = 2'b00;

    // Reset state
    exp_q.push_back(idle_rec(1'b0));
    exp_q.push_back(idle_rec(1'b0));
    tick("reset");
    tick("reset");
    reset_i = 1'b0;
    exp_q.push_back(idle_rec(1'b0));
    tick("idle_after_reset");
    $display("reset: idle state checked");

    // Table-driven single permutations and the reserved mode
    for (int v = 0; v < 4; v++) begin
      bad0    = miscompares;
      mode_i  = vecs[v].mode;
      start_i = 1'b1;
      if (vecs[v].is_err) begin
        exp_q.push_back(idle_rec(1'b1));
        exp_q.push_back(idle_rec(1'b0));
        exp_q.push_back(idle_rec(1'b0));
      end else begin
        push_perm(vecs[v].start_idx, vecs[v].n_rounds);
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        tick($sformatf("vec%0d_cyc%0d", v, i));
        if (i == 0) start_i = 1'b0;
      end
      exp_q.push_back(idle_rec(1'b0));
      tick($sformatf("vec%0d_tail", v));
      $display("vec %0d mode=%b start=%0d rounds=%0d err=%0d: %0d miscompares",
               v, vecs[v].mode, vecs[v].start_idx, vecs[v].n_rounds, vecs[v].is_err,
               miscompares - bad0);
    end

    // start held high with p6: back-to-back runs every 8 cycles
    bad0    = miscompares;
    mode_i  = 2'b10;
    start_i = 1'b1;
    for (int k = 0; k < 3; k++) push_perm(6, 6);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick($sformatf("hold_cyc%0d", i));
      if (i == n - 2) start_i = 1'b0;
    end
    exp_q.push_back(idle_rec(1'b0));
    tick("hold_tail");
    $display("hold-start p6 x3: %0d miscompares", miscompares - bad0);

    // mode_i changes mid-run; run length follows the accepted mode
    bad0    = miscompares;
    mode_i  = 2'b10;
    start_i = 1'b1;
    push_perm(6, 6);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      tick($sformatf("modechg_cyc%0d", i));
      if (i == 0) begin
        start_i = 1'b0;
        mode_i  = 2'b00;
      end
    end
    $display("mode change during p6: %0d miscompares", miscompares - bad0);

    // Reset on the 5th RUN cycle of p12 aborts with no done pulse
    bad0    = miscompares;
    mode_i  = 2'b00;
    start_i = 1'b1;
    for (int r = 0; r < 5; r++) exp_q.push_back(run_rec(r, r == 0));
    for (int i = 0; i < 5; i++) begin
      tick($sformatf("abort_run%0d", i));
      if (i == 0) start_i = 1'b0;
    end
    reset_i = 1'b1;
    exp_q.push_back(idle_rec(1'b0));
    tick("abort_reset");
    reset_i = 1'b0;
    for (int i = 0; i < 14; i++) exp_q.push_back(idle_rec(1'b0));
    for (int i = 0; i < 14; i++) tick($sformatf("abort_idle%0d", i));
    $display("reset mid-p12: %0d miscompares", miscompares - bad0);

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d unconsumed expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ascon_round_ctrl.md
Name: ascon_round_ctrl

Overview:
- Sequences the ASCON permutation datapath, one round per clock.
- Drives the 4-bit round index consumed by the constant-addition layer, the state-register enable and the initial-state mux select.
- Supports p12, p8 and p6 by choosing the start round index; reports completion to the mode-level FSM.
- Sits between the top-level ASCON mode FSM and the permutation round datapath.

Parameters:
- ROUND_W, 4, width of the round index (indexes the 12-entry round constant table).
- LAST_ROUND, 11, index of the final round for every permutation variant.

Ports:
- clock_i  in  1  system clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a permutation; accepted only when ready_o=1.
- mode_i  in  2  permutation length: 00=p12, 01=p8, 10=p6, 11=reserved.
- ready_o  out  1  controller idle, start_i will be accepted.
- round_o  out  ROUND_W  round index to the constant-addition layer.
- en_state_o  out  1  state-register write enable for the round datapath.
- sel_init_o  out  1  state mux selects the external initial state (first round only).
- busy_o  out  1  permutation in progress.
- done_o  out  1  one-cycle pulse; the state register holds the permutation result.
- err_o  out  1  one-cycle pulse; start_i was presented with the reserved mode.

Behaviour:
- Reset (reset_i=1 at a clock edge, any state): state=IDLE, round_o=0, ready_o=1, en_state_o=0, sel_init_o=0, busy_o=0, done_o=0, err_o=0.
  - Reset mid-RUN aborts immediately.
  - No done_o is produced for the aborted permutation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1, busy_o=0.
  - start_i=1 with mode_i in {00,01,10}: next state RUN. round_o loads the start index: 0 for p12, 4 for p8, 6 for p6.
  - start_i=1 with mode_i=11: stay IDLE, err_o=1 for the next cycle only, round_o unchanged.
- RUN:
  - en_state_o=1, busy_o=1, ready_o=0.
  - sel_init_o=1 only in the first RUN cycle after acceptance.
  - round_o increments by 1 each cycle.
  - When round_o==LAST_ROUND, next state DONE and round_o returns to 0.
  - start_i is ignored; mode_i is sampled only at acceptance.
- DONE:
  - Lasts exactly one cycle: done_o=1, en_state_o=0, busy_o=0, ready_o=0. Then IDLE.
  - start_i in DONE is ignored; back-to-back permutations need a new start_i in IDLE.
- Latency: start accepted at cycle T.
  - RUN occupies T+1 .. T+N, where N = 12, 8 or 6.
  - done_o is asserted at T+N+1.
  - ready_o=1 again at T+N+2.
- round_o never exceeds LAST_ROUND. All outputs are registered or decoded from registered state only; no combinational path from start_i to any output.

Decomposition:
- Shared package additions:
  - enum type_round_mode {P12, P8, P6, RSVD};
  - start-index constants ROUND_START_P12=0, ROUND_START_P8=4, ROUND_START_P6=6;
  - LAST_ROUND=11.
- The round-constant table stays in the package.
- One natural sub-module: round_counter. It is a loadable 4-bit up-counter with load value, enable and a terminal flag at LAST_ROUND. The FSM sits in ascon_round_ctrl itself.

Test Plan:
- Reset then start_i=1, mode_i=00 at T:
  - round_o = 0,1,...,11 on T+1..T+12;
  - en_state_o=1 for exactly 12 cycles, sel_init_o=1 only at T+1;
  - done_o=1 at T+13; ready_o=1 at T+14.
- mode_i=01 (p8): round_o = 4..11 over 8 cycles, done_o at T+9. mode_i=10 (p6): round_o = 6..11 over 6 cycles, done_o at T+7.
- start_i=1 with mode_i=11 in IDLE: err_o pulses 1 cycle; state stays IDLE; en_state_o never asserted; ready_o stays 1.
- start_i held high continuously, mode_i=10: permutations repeat with period 8 cycles (6 RUN + DONE + IDLE); start_i during RUN/DONE has no effect.
- reset_i=1 at the 5th RUN cycle of p12: next cycle round_o=0, ready_o=1, busy_o=0, and done_o never pulses.
- mode_i changed to 00 during a p6 run: the run still ends after 6 rounds at round_o=11.
